// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU and MEM
// writeback paths, with a busy-bit scoreboard that holds off ALU writes to MEM-reserved registers.
module rf_write_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               alu_valid,
    input  logic [AW-1:0]      alu_rd,
    input  logic [XLEN-1:0]    alu_data,
    output logic               alu_ready,
    input  logic               mem_valid,
    input  logic [AW-1:0]      mem_rd,
    input  logic [XLEN-1:0]    mem_data,
    output logic               mem_ready,
    input  logic               rsv_valid,
    input  logic [AW-1:0]      rsv_rd,
    output logic [2**AW-1:0]   busy,
    output logic               rf_regwrite,
    output logic [AW-1:0]      rf_rd,
    output logic [XLEN-1:0]    rf_writedata
);
    localparam int NREG = 2**AW;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

    grant_t            last_grant_reg;
    logic [NREG-1:0]   busy_reg;
    logic [NREG-1:0]   busy_next;
    logic              rf_regwrite_reg;
    logic [AW-1:0]     rf_rd_reg;
    logic [XLEN-1:0]   rf_writedata_reg;

    logic alu_elig;
    logic mem_elig;
    logic alu_grant;
    logic mem_grant;

    // ALU is held off while its destination awaits a MEM write; MEM is never blocked.
    always_comb begin
        alu_elig  = alu_valid & ~busy_reg[alu_rd];
        mem_elig  = mem_valid;
        alu_grant = alu_elig & (~mem_elig | (last_grant_reg == GRANT_MEM));
        mem_grant = mem_elig & (~alu_elig | (last_grant_reg == GRANT_ALU));
    end

    assign alu_ready = alu_grant;
    assign mem_ready = mem_grant;

    // x0 never becomes busy; for the rest a reservation outranks a same-cycle MEM clear.
    assign busy_next[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
            assign busy_next[gi] = (rsv_valid && (rsv_rd == AW'(gi)))
                                 | (busy_reg[gi] & ~(mem_grant && (mem_rd == AW'(gi))));
        end
    endgenerate

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_grant_reg   <= GRANT_MEM;
            busy_reg         <= '0;
            rf_regwrite_reg  <= 1'b0;
            rf_rd_reg        <= '0;
            rf_writedata_reg <= '0;
        end else begin
            busy_reg <= busy_next;
            if (alu_grant) begin
                last_grant_reg   <= GRANT_ALU;
                rf_regwrite_reg  <= (alu_rd != '0);
                rf_rd_reg        <= alu_rd;
                rf_writedata_reg <= alu_data;
            end else if (mem_grant) begin
                last_grant_reg   <= GRANT_MEM;
                rf_regwrite_reg  <= (mem_rd != '0);
                rf_rd_reg        <= mem_rd;
                rf_writedata_reg <= mem_data;
            end else begin
                rf_regwrite_reg  <= 1'b0;
            end
        end
    end

    assign busy         = busy_reg;
    assign rf_regwrite  = rf_regwrite_reg;
    assign rf_rd        = rf_rd_reg;
    assign rf_writedata = rf_writedata_reg;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the write port.
module tb_rf_write_arbiter;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREG = 2**AW;

    logic              clock = 1'b0;
    logic              resetn;
    logic              alu_valid, mem_valid, rsv_valid;
    logic [AW-1:0]     alu_rd, mem_rd, rsv_rd;
    logic [XLEN-1:0]   alu_data, mem_data;
    logic              alu_ready, mem_ready;
    logic [NREG-1:0]   busy;
    logic              rf_regwrite;
    logic [AW-1:0]     rf_rd;
    logic [XLEN-1:0]   rf_writedata;

    int n_cmp  = 0;
    int n_fail = 0;

    // behavioural model state
    logic [NREG-1:0]   m_busy;
    bit                m_last_mem;
    logic              m_we;
    logic [AW-1:0]     m_rd;
    logic [XLEN-1:0]   m_data;

    rf_write_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .mem_valid    (mem_valid),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .rsv_valid    (rsv_valid),
        .rsv_rd       (rsv_rd),
        .busy         (busy),
        .rf_regwrite  (rf_regwrite),
        .rf_rd        (rf_rd),
        .rf_writedata (rf_writedata)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        m_busy     = '0;
        m_last_mem = 1'b1;
        m_we       = 1'b0;
        m_rd       = '0;
        m_data     = '0;
    endtask

    // {alu_grant, mem_grant} from the eligibility and round-robin rules
    function automatic logic [1:0] model_grant();
        bit alu_e, mem_e;
        alu_e = alu_valid && !m_busy[alu_rd];
        mem_e = mem_valid;
        if (alu_e && mem_e) return m_last_mem ? 2'b10 : 2'b01;
        return {alu_e, mem_e};
    endfunction

    task automatic clear_inputs();
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        mem_valid = 0; mem_rd = '0; mem_data = '0;
        rsv_valid = 0; rsv_rd = '0;
    endtask

    task automatic settle();
        #2;
    endtask

    // Apply the current inputs to the model, then move to 1ns after the next edge.
    task automatic advance();
        logic [1:0] g;
        g = model_grant();
        if (g[1]) begin
            m_we = (alu_rd != 0); m_rd = alu_rd; m_data = alu_data; m_last_mem = 1'b0;
            $display("xfer ALU rd=%0d data=%h", alu_rd, alu_data);
        end else if (g[0]) begin
            m_we = (mem_rd != 0); m_rd = mem_rd; m_data = mem_data; m_last_mem = 1'b1;
            $display("xfer MEM rd=%0d data=%h", mem_rd, mem_data);
        end else begin
            m_we = 1'b0;
        end
        if (g[0] && mem_rd != 0) m_busy[mem_rd] = 1'b0;
        if (rsv_valid && rsv_rd != 0) m_busy[rsv_rd] = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn = 0;
        repeat (2) @(posedge clock);
        #1 resetn = 1;
        model_reset();
        n_cmp++; if (rf_regwrite !== 1'b0 || busy !== '0) begin n_fail++;
            $display("FAIL reset_init: regwrite=%b busy=%h required 0/0", rf_regwrite, busy); end
        alu_valid = 1; alu_rd = 7; alu_data = 32'h55; rsv_valid = 1; rsv_rd = 9;
        settle();
        advance();
        n_cmp++; if (rf_regwrite !== m_we || busy !== m_busy) begin n_fail++;
            $display("FAIL reset_pre: regwrite=%b busy=%h required %b/%h", rf_regwrite, busy, m_we, m_busy); end
        alu_rd = 8; alu_data = 32'h66; rsv_valid = 0;
        #2 resetn = 0;
        #1;
        n_cmp++; if ({rf_regwrite, rf_rd, rf_writedata} !== '0 || busy !== '0) begin n_fail++;
            $display("FAIL reset_async: we=%b rd=%0d data=%h busy=%h required all 0",
                     rf_regwrite, rf_rd, rf_writedata, busy); end
        alu_valid = 0;
        @(posedge clock);
        #1 resetn = 1;
        model_reset();
        alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
        settle();
        n_cmp++; if (alu_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_first_ready: alu_ready=%b required 1", alu_ready); end
        advance();
        n_cmp++; if (rf_regwrite !== 1'b1 || rf_rd !== 5'd3 || rf_writedata !== 32'h11) begin n_fail++;
            $display("FAIL reset_first_write: we=%b rd=%0d data=%h required 1/3/11",
                     rf_regwrite, rf_rd, rf_writedata); end
        alu_valid = 0;
    endtask

    task automatic test_contention();
        resetn = 0;
        #1 resetn = 1;
        model_reset();
        alu_valid = 1; alu_rd = 4; alu_data = 32'h44;
        mem_valid = 1; mem_rd = 10; mem_data = 32'hAA;
        for (int i = 0; i < 8; i++) begin
            settle();
            n_cmp++; if (alu_ready !== (i % 2 == 0) || mem_ready !== (i % 2 == 1)) begin n_fail++;
                $display("FAIL contention_grant[%0d]: alu_ready=%b mem_ready=%b required %b/%b",
                         i, alu_ready, mem_ready, (i % 2 == 0), (i % 2 == 1)); end
            advance();
            n_cmp++; if (rf_regwrite !== 1'b1 || rf_rd !== ((i % 2 == 0) ? 5'd4 : 5'd10)) begin n_fail++;
                $display("FAIL contention_write[%0d]: we=%b rd=%0d required 1/%0d",
                         i, rf_regwrite, rf_rd, (i % 2 == 0) ? 4 : 10); end
        end
        clear_inputs();
    endtask

    task automatic test_x0();
        alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF;
        settle();
        n_cmp++; if (alu_ready !== 1'b1) begin n_fail++;
            $display("FAIL x0_ready: alu_ready=%b required 1", alu_ready); end
        advance();
        n_cmp++; if (rf_regwrite !== 1'b0) begin n_fail++;
            $display("FAIL x0_write: rf_regwrite=%b required 0", rf_regwrite); end
        alu_valid = 0; rsv_valid = 1; rsv_rd = 0;
        settle();
        advance();
        n_cmp++; if (busy !== '0) begin n_fail++;
            $display("FAIL x0_rsv: busy=%h required 0", busy); end
        rsv_valid = 0;
        // x0 transfer counted as an ALU grant, so a tie now goes to MEM
        alu_valid = 1; alu_rd = 1; alu_data = 32'h1;
        mem_valid = 1; mem_rd = 2; mem_data = 32'h2;
        settle();
        n_cmp++; if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin n_fail++;
            $display("FAIL x0_rr: alu_ready=%b mem_ready=%b required 0/1", alu_ready, mem_ready); end
        advance();
        clear_inputs();
    endtask

    task automatic test_waw();
        rsv_valid = 1; rsv_rd = 5;
        settle();
        advance();
        rsv_valid = 0;
        n_cmp++; if (busy[5] !== 1'b1) begin n_fail++;
            $display("FAIL waw_rsv: busy[5]=%b required 1", busy[5]); end
        alu_valid = 1; alu_rd = 5; alu_data = 32'h99;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_cmp++; if (alu_ready !== 1'b0) begin n_fail++;
                $display("FAIL waw_block[%0d]: alu_ready=%b required 0", i, alu_ready); end
            advance();
        end
        mem_valid = 1; mem_rd = 5; mem_data = 32'h7;
        settle();
        n_cmp++; if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin n_fail++;
            $display("FAIL waw_mem: alu_ready=%b mem_ready=%b required 0/1", alu_ready, mem_ready); end
        advance();
        mem_valid = 0;
        n_cmp++; if (busy[5] !== 1'b0 || rf_regwrite !== 1'b1 || rf_rd !== 5'd5 || rf_writedata !== 32'h7) begin
            n_fail++;
            $display("FAIL waw_memwrite: busy5=%b we=%b rd=%0d data=%h required 0/1/5/7",
                     busy[5], rf_regwrite, rf_rd, rf_writedata); end
        settle();
        n_cmp++; if (alu_ready !== 1'b1) begin n_fail++;
            $display("FAIL waw_alu_after: alu_ready=%b required 1", alu_ready); end
        advance();
        n_cmp++; if (rf_regwrite !== 1'b1 || rf_rd !== 5'd5 || rf_writedata !== 32'h99) begin n_fail++;
            $display("FAIL waw_aluwrite: we=%b rd=%0d data=%h required 1/5/99",
                     rf_regwrite, rf_rd, rf_writedata); end
        clear_inputs();
    endtask

    task automatic test_collision();
        mem_valid = 1; mem_rd = 6; mem_data = 32'h3; rsv_valid = 1; rsv_rd = 6;
        settle();
        advance();
        n_cmp++; if (busy[6] !== 1'b1) begin n_fail++;
            $display("FAIL collision_set: busy[6]=%b required 1", busy[6]); end
        rsv_valid = 0; mem_data = 32'h4;
        settle();
        advance();
        n_cmp++; if (busy[6] !== 1'b0) begin n_fail++;
            $display("FAIL collision_clear: busy[6]=%b required 0", busy[6]); end
        clear_inputs();
    endtask

    task automatic test_idle();
        logic [AW-1:0]   held_rd;
        logic [XLEN-1:0] held_data;
        held_rd = m_rd; held_data = m_data;
        for (int i = 0; i < 3; i++) begin
            settle();
            advance();
            n_cmp++; if (rf_regwrite !== 1'b0 || rf_rd !== held_rd || rf_writedata !== held_data) begin
                n_fail++;
                $display("FAIL idle[%0d]: we=%b rd=%0d data=%h required 0/%0d/%h",
                         i, rf_regwrite, rf_rd, rf_writedata, held_rd, held_data); end
        end
    endtask

    task automatic test_random();
        logic [1:0] g;
        int r;
        for (int c = 0; c < 300; c++) begin
            if (!alu_valid && $urandom_range(0, 2) != 0) begin
                alu_valid = 1; alu_rd = AW'($urandom_range(0, 7)); alu_data = $urandom;
            end
            if (!mem_valid && $urandom_range(0, 2) != 0) begin
                mem_valid = 1; mem_data = $urandom;
                if (m_busy[7:1] != 0 && $urandom_range(0, 1) == 1) begin
                    do r = $urandom_range(1, 7); while (!m_busy[r]);
                    mem_rd = AW'(r);
                end else begin
                    mem_rd = AW'($urandom_range(0, 7));
                end
            end
            rsv_valid = ($urandom_range(0, 4) == 0);
            rsv_rd    = AW'($urandom_range(0, 7));
            settle();
            g = model_grant();
            n_cmp++; if ({alu_ready, mem_ready} !== g) begin n_fail++;
                $display("FAIL rand_grant[%0d]: alu/mem ready=%b%b required %b", c, alu_ready, mem_ready, g); end
            advance();
            n_cmp++; if (rf_regwrite !== m_we || rf_rd !== m_rd || rf_writedata !== m_data || busy !== m_busy) begin
                n_fail++;
                $display("FAIL rand_state[%0d]: we=%b rd=%0d data=%h busy=%h required %b/%0d/%h/%h",
                         c, rf_regwrite, rf_rd, rf_writedata, busy, m_we, m_rd, m_data, m_busy); end
            if (g[1]) alu_valid = 0;
            if (g[0]) mem_valid = 0;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_x0();
        test_waw();
        test_collision();
        test_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
